// File: rtl/sprite_attr_regs.sv
// Double-buffered sprite attribute registers on an Avalon-MM slave.
// Pending descriptors are committed to the active sprite outputs at the start of vertical blank.
module sprite_attr_regs #(
    parameter int VBLANK_LINE = 480,
    parameter int FRAME_LINES = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [2:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  VGA_VCOUNT,
    output logic [31:0] sprite1,
    output logic [31:0] sprite2,
    output logic [31:0] sprite3,
    output logic        irq
);

    localparam logic [2:0] ADDR_CTRL    = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;
    localparam logic [9:0] VBL_LINE     = 10'(VBLANK_LINE);
    // A blank line configured outside the frame can never be reached, so it never commits.
    localparam bit         VBL_IN_FRAME = (VBLANK_LINE < FRAME_LINES);

    logic [31:0] pend [3];
    logic [31:0] act  [3];
    logic        arm;
    logic        irq_en;
    logic        vbf;
    logic [15:0] frame_cnt;
    logic [9:0]  vprev;
    logic        edge_ok;
    logic        wr_en;
    logic        rd_en;
    logic        vbl_start;
    logic        commit;
    logic [31:0] rd_mux;

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;

    // edge_ok keeps the first cycle after reset release from seeing a false line-480 entry.
    assign vbl_start = VBL_IN_FRAME && edge_ok &&
                       (VGA_VCOUNT == VBL_LINE) && (vprev != VBL_LINE);
    assign commit    = vbl_start & arm;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vprev   <= '0;
            edge_ok <= 1'b0;
        end else begin
            vprev   <= VGA_VCOUNT;
            edge_ok <= 1'b1;
        end
    end

    // NOTE: the descriptor arrays are only six words of flops, so they are reset like any other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wr_en && address == 3'(i)) begin
                    pend[i] <= writedata;
                end
                if (commit) begin
                    act[i] <= pend[i];
                end
            end
        end
    end

    // A CTRL write outranks the commit-clear, so ARM set during the blank-start cycle survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm       <= 1'b0;
            irq_en    <= 1'b0;
            vbf       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (wr_en && address == ADDR_CTRL) begin
                arm    <= writedata[0];
                irq_en <= writedata[1];
            end else if (vbl_start) begin
                arm    <= 1'b0;
            end

            if (vbl_start) begin
                vbf       <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (wr_en && address == ADDR_STATUS && writedata[1]) begin
                vbf       <= 1'b0;
            end
        end
    end

    // NOTE: rd_mux gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0: rd_mux = pend[0];
            3'd1: rd_mux = pend[1];
            3'd2: rd_mux = pend[2];
            3'd3: rd_mux = {30'd0, irq_en, arm};
            3'd4: rd_mux = {frame_cnt, 14'd0, vbf, arm};
            3'd5: rd_mux = act[0];
            3'd6: rd_mux = act[1];
            3'd7: rd_mux = act[2];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

    assign sprite1 = act[0];
    assign sprite2 = act[1];
    assign sprite3 = act[2];
    assign irq     = vbf & irq_en;

endmodule

// File: tb/tb_sprite_attr_regs.sv
// Directed testbench for sprite_attr_regs: register access, vertical-blank commit,
// interrupt behaviour and reset.
module tb_sprite_attr_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [9:0]  vga_vcount = '0;
    logic [31:0] sprite1, sprite2, sprite3;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_frames = '0;
    logic [31:0] rd;

    sprite_attr_regs #(.VBLANK_LINE(480), .FRAME_LINES(525)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .VGA_VCOUNT (vga_vcount),
        .sprite1    (sprite1),
        .sprite2    (sprite2),
        .sprite3    (sprite3),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // Steps 479 -> 480; returns at the negedge just after the blank-start edge.
    task automatic enter_vblank();
        @(negedge clk); vga_vcount = 10'd479;
        @(negedge clk); vga_vcount = 10'd480;
        @(negedge clk);
        exp_frames = exp_frames + 16'd1;
    endtask

    task automatic leave_vblank();
        @(negedge clk); vga_vcount = 10'd0;
    endtask

    // Bus write landing on the same edge as the blank start.
    task automatic vbl_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk); vga_vcount = 10'd479;
        @(negedge clk); vga_vcount = 10'd480;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        exp_frames = exp_frames + 16'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sprite1, sprite2, sprite3} !== 96'd0) begin
            errors++; $display("FAIL reset_sprites: got %h expected 0", {sprite1, sprite2, sprite3});
        end
        checks++;
        if ({irq, readdata} !== 33'd0) begin
            errors++; $display("FAIL reset_irq_readdata: got irq=%b rd=%h expected 0", irq, readdata);
        end
        // Release reset while the line counter already sits on the blank line.
        vga_vcount = 10'd480;
        @(negedge clk); #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(3'd4, rd);
        checks++;
        if (rd !== 32'h0000_0000) begin
            errors++; $display("FAIL release_on_vbl_status: got %h expected 00000000", rd);
        end
        vga_vcount = 10'd0;
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 00000000", rd);
        end
    endtask

    task automatic test_basic_commit();
        bus_write(3'd0, 32'h0A20_3264);
        bus_write(3'd3, 32'h1);
        checks++;
        if (sprite1 !== 32'h0) begin
            errors++; $display("FAIL commit_early: got %h expected 00000000", sprite1);
        end
        enter_vblank();
        checks++;
        if (sprite1 !== 32'h0A20_3264 || sprite2 !== 32'h0) begin
            errors++; $display("FAIL commit_sprite1: got %h/%h expected 0a203264/00000000", sprite1, sprite2);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL commit_irq_disabled: got %b expected 0", irq);
        end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== {exp_frames, 14'd0, 2'b10}) begin
            errors++; $display("FAIL commit_status: got %h expected %h", rd, {exp_frames, 14'd0, 2'b10});
        end
        leave_vblank();
    endtask

    task automatic test_readonly();
        bus_write(3'd5, 32'hFFFF_FFFF);
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h0A20_3264 || sprite1 !== 32'h0A20_3264) begin
            errors++; $display("FAIL act_write_ignored: got rd=%h s1=%h expected 0a203264", rd, sprite1);
        end
        bus_write(3'd4, 32'hFFFF_FFFD);
        bus_read(3'd4, rd);
        checks++;
        if (rd !== {exp_frames, 14'd0, 2'b10}) begin
            errors++; $display("FAIL status_ro_bits: got %h expected %h", rd, {exp_frames, 14'd0, 2'b10});
        end
    endtask

    task automatic test_arm_gate();
        bus_write(3'd1, 32'h1230_0005);
        enter_vblank(); leave_vblank();
        enter_vblank(); leave_vblank();
        checks++;
        if (sprite2 !== 32'h0) begin
            errors++; $display("FAIL unarmed_hold: got %h expected 00000000", sprite2);
        end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== {exp_frames, 14'd0, 2'b10}) begin
            errors++; $display("FAIL frame_count_unarmed: got %h expected %h", rd, {exp_frames, 14'd0, 2'b10});
        end
        bus_write(3'd3, 32'h1);
        repeat (5) @(negedge clk);
        checks++;
        if (sprite2 !== 32'h0) begin
            errors++; $display("FAIL armed_midframe: got %h expected 00000000", sprite2);
        end
        enter_vblank();
        checks++;
        if (sprite2 !== 32'h1230_0005 || sprite1 !== 32'h0A20_3264) begin
            errors++; $display("FAIL armed_commit: got %h/%h expected 12300005/0a203264", sprite2, sprite1);
        end
        leave_vblank();
    endtask

    task automatic test_vbl_cycle_writes();
        bus_write(3'd2, 32'h2222_0001);
        bus_write(3'd3, 32'h1);
        vbl_write(3'd2, 32'h3333_0002);
        checks++;
        if (sprite3 !== 32'h2222_0001) begin
            errors++; $display("FAIL pend_write_on_vbl: got %h expected 22220001", sprite3);
        end
        bus_read(3'd2, rd);
        checks++;
        if (rd !== 32'h3333_0002) begin
            errors++; $display("FAIL pend_kept_new: got %h expected 33330002", rd);
        end
        leave_vblank();
        vbl_write(3'd3, 32'h1);
        checks++;
        if (sprite3 !== 32'h2222_0001) begin
            errors++; $display("FAIL arm_on_vbl_no_commit: got %h expected 22220001", sprite3);
        end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++; $display("FAIL arm_on_vbl_kept: got %h expected 00000001", rd);
        end
        leave_vblank();
        enter_vblank();
        checks++;
        if (sprite3 !== 32'h3333_0002) begin
            errors++; $display("FAIL arm_next_frame: got %h expected 33330002", sprite3);
        end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL arm_cleared: got %h expected 00000000", rd);
        end
        leave_vblank();
    endtask

    task automatic test_arm_cancel();
        bus_write(3'd0, 32'h4444_0003);
        bus_write(3'd3, 32'h1);
        bus_write(3'd3, 32'h0);
        enter_vblank();
        checks++;
        if (sprite1 !== 32'h0A20_3264) begin
            errors++; $display("FAIL arm_cancel: got %h expected 0a203264", sprite1);
        end
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h4444_0003) begin
            errors++; $display("FAIL cancel_keeps_pend: got %h expected 44440003", rd);
        end
        leave_vblank();
    endtask

    task automatic test_irq();
        bus_write(3'd3, 32'h2);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_enable: got %b expected 1", irq);
        end
        bus_write(3'd4, 32'h2);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear: got %b expected 0", irq);
        end
        enter_vblank();
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_on_vbl: got %b expected 1", irq);
        end
        leave_vblank();
        bus_write(3'd4, 32'h2);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear2: got %b expected 0", irq);
        end
        vbl_write(3'd4, 32'h2);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_set_wins: got %b expected 1", irq);
        end
        leave_vblank();
        bus_write(3'd4, 32'h1);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_bit0_noclear: got %b expected 1", irq);
        end
    endtask

    task automatic test_hold_480();
        enter_vblank();
        repeat (800) @(negedge clk);
        bus_read(3'd4, rd);
        checks++;
        if (rd !== {exp_frames, 14'd0, 2'b10}) begin
            errors++; $display("FAIL hold_480_single: got %h expected %h", rd, {exp_frames, 14'd0, 2'b10});
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); vga_vcount = 10'd0;
            @(negedge clk); vga_vcount = 10'd480;
            exp_frames = exp_frames + 16'd1;
        end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== {exp_frames, 14'd0, 2'b10}) begin
            errors++; $display("FAIL fast_frames_count: got %h expected %h", rd, {exp_frames, 14'd0, 2'b10});
        end
        vga_vcount = 10'd0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 3'd0; writedata = 32'h0F0F_0F0F;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        checks++;
        if (readdata !== 32'h4444_0003) begin
            errors++; $display("FAIL rw_same_cycle: got %h expected 44440003", readdata);
        end
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 3'd0;
        @(negedge clk);
        address = 3'd5;
        checks++;
        if (readdata !== 32'h0F0F_0F0F) begin
            errors++; $display("FAIL b2b_read0: got %h expected 0f0f0f0f", readdata);
        end
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0; address = 3'd1;
        repeat (3) @(negedge clk);
        checks++;
        if (readdata !== 32'h0A20_3264) begin
            errors++; $display("FAIL b2b_read5_hold: got %h expected 0a203264", readdata);
        end
    endtask

    task automatic test_reset_midframe();
        bus_write(3'd1, 32'h7F1F_FFFF);
        bus_write(3'd3, 32'h3);
        bus_read(3'd0, rd);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq);
        end
        @(negedge clk); #2 reset = 1'b0;
        #1;
        checks++;
        if ({sprite1, sprite2, sprite3} !== 96'd0) begin
            errors++; $display("FAIL async_reset_sprites: got %h expected 0", {sprite1, sprite2, sprite3});
        end
        checks++;
        if ({irq, readdata} !== 33'd0) begin
            errors++; $display("FAIL async_reset_irq_rd: got irq=%b rd=%h expected 0", irq, readdata);
        end
        exp_frames = '0;
        @(negedge clk); #2 reset = 1'b1;
        enter_vblank();
        checks++;
        if ({sprite1, sprite2, sprite3} !== 96'd0) begin
            errors++; $display("FAIL no_commit_after_reset: got %h expected 0", {sprite1, sprite2, sprite3});
        end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== {exp_frames, 14'd0, 2'b10}) begin
            errors++; $display("FAIL status_after_reset: got %h expected %h", rd, {exp_frames, 14'd0, 2'b10});
        end
        bus_read(3'd1, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL pend_after_reset: got %h expected 00000000", rd);
        end
        leave_vblank();
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_readonly();
        test_arm_gate();
        test_vbl_cycle_writes();
        test_arm_cancel();
        test_irq();
        test_hold_480();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
